// File: rtl/mem_arbiter_if.sv
// Bundle of requester ports and RAM command/response signals for mem_arbiter.
// The slave modport is the arbiter; master is the environment (both requesters plus the RAM).
interface mem_arbiter_if;
  logic        req0;
  logic        req1;
  logic [8:0]  addr0;
  logic [8:0]  addr1;
  logic        rw0;
  logic        rw1;
  logic [1:0]  size0;
  logic [1:0]  size1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic        err;
  logic [31:0] rdata;
  logic        ramMFA;
  logic        ramRW;
  logic [8:0]  ramAddress;
  logic [1:0]  ramDataSize;
  logic [31:0] ramDataIn;
  logic [31:0] ramDataOut;
  logic        ramMFC;

  modport slave (
    input  req0, req1, addr0, addr1, rw0, rw1, size0, size1, wdata0, wdata1,
    input  ramDataOut, ramMFC,
    output ack0, ack1, err, rdata,
    output ramMFA, ramRW, ramAddress, ramDataSize, ramDataIn
  );

  modport master (
    output req0, req1, addr0, addr1, rw0, rw1, size0, size1, wdata0, wdata1,
    output ramDataOut, ramMFC,
    input  ack0, ack1, err, rdata,
    input  ramMFA, ramRW, ramAddress, ramDataSize, ramDataIn
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single MFA/MFC handshake RAM.
// Every output is a register or a decode of registered state, so no input reaches an output combinationally.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t      state;
  state_t      state_next;
  logic        any_req;
  logic        winner;
  logic        owner;
  logic        last_grant;
  logic [7:0]  count;
  logic        rw_q;
  logic [8:0]  addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    winner  = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner = ~last_grant;
    end else if (bus.req1) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.ramMFC || count == TIMEOUT_CNT) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command fields are captured once at grant time so requester activity during the access cannot leak to the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      rw_q       <= 1'b1;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= winner;
            last_grant <= winner;
            count      <= 8'd1;
            rw_q       <= winner ? bus.rw1    : bus.rw0;
            addr_q     <= winner ? bus.addr1  : bus.addr0;
            size_q     <= winner ? bus.size1  : bus.size0;
            wdata_q    <= winner ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: begin
          // A completion on the final allowed cycle still counts as success.
          if (bus.ramMFC) begin
            rdata_q <= bus.ramDataOut;
            err_q   <= 1'b0;
          end else if (count == TIMEOUT_CNT) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ramMFA      = (state == ACCESS);
  assign bus.ramRW       = rw_q;
  assign bus.ramAddress  = addr_q;
  assign bus.ramDataSize = size_q;
  assign bus.ramDataIn   = wdata_q;
  assign bus.ack0        = (state == RESP) && !owner;
  assign bus.ack1        = (state == RESP) && owner;
  assign bus.err         = err_q;
  assign bus.rdata       = rdata_q;

endmodule
